hdu_scoreboard: RTL and testbench

- Sequential successor to the combinational HDU of the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
- Keeps a per-register pending-write scoreboard, replacing the stage-by-stage instruction compare.
- Produces the ID-stage stall, per-operand forwarding selects (when forwarding is enabled), a busy vector and a saturating stall-cycle counter.
- Generalised in register-file size and hazard mode; adds load-use handling.

---
 rtl/hdu_pkg.sv | 50 +++++
 rtl/hdu_sb_entry.sv | 46 ++++
 rtl/hdu_scoreboard.sv | 115 +++++++++++
 tb/tb_hdu_scoreboard.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hdu_pkg.sv
// Shared opcode/forwarding encodings and opcode-class decode helpers
// for the scoreboard-based hazard detection unit.
package hdu_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_LD  = 3'd4;
    localparam logic [2:0] OP_ST  = 3'd5;
    localparam logic [2:0] OP_BR  = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b11;

    function automatic logic reads_r1(input logic [2:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_ST, OP_BR: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic reads_r2(input logic [2:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_LD, OP_ST: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic writes_r1(input logic [2:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_LD: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        return (op == OP_LD);
    endfunction

endpackage

// File: rtl/hdu_sb_entry.sv
// One scoreboard entry: pending-write countdown (3=EX, 2=MEM, 1=WB, 0=done)
// plus a load flag that lives as long as the countdown is nonzero.
module hdu_sb_entry
    import hdu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_i,
    input  logic       set_ld_i,
    output logic [1:0] cnt_o,
    output logic       ld_o
);

    logic [1:0] cnt_q, cnt_d;
    logic       ld_q, ld_d;

    // Next-state: a new writer overrides the countdown of an older one.
    always_comb begin
        cnt_d = cnt_q;
        ld_d  = ld_q;
        if (set_i) begin
            cnt_d = 2'd3;
            ld_d  = set_ld_i;
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
            ld_d  = (cnt_q == 2'd1) ? 1'b0 : ld_q;
        end else begin
            ld_d  = 1'b0;
        end
    end

    // Entry state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            ld_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ld_q  <= ld_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ld_o  = ld_q;

endmodule

// File: rtl/hdu_scoreboard.sv
// Scoreboard-based hazard detection: per-register pending-write tracking,
// ID-stage stall, operand forwarding selects and a saturating stall counter.
module hdu_scoreboard
    import hdu_pkg::*;
#(
    parameter int REG_W  = 2,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16,
    localparam int NUM_REGS = 2**REG_W,
    localparam int INSTR_W  = 2*REG_W+4
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  id_instr,
    input  logic                id_valid,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          fwd_sel_a,
    output logic [1:0]          fwd_sel_b,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    stall_count
);

    logic [2:0]       op_s;
    logic [REG_W-1:0] r1_s, r2_s;
    logic             mode_unused_s;

    assign mode_unused_s = id_instr[INSTR_W-1];
    assign op_s = id_instr[2*REG_W+2:2*REG_W];
    assign r1_s = id_instr[2*REG_W-1:REG_W];
    assign r2_s = id_instr[REG_W-1:0];

    logic [1:0] cnt_s [NUM_REGS];
    logic       ld_s  [NUM_REGS];
    logic       issue_s, stall_s, haz_a_s, haz_b_s;

    function automatic logic src_hazard(input logic [1:0] c, input logic l);
        if (FWD_EN != 0) begin
            return (c == 2'd3) && l;
        end else begin
            return (c != 2'd0);
        end
    endfunction

    function automatic logic [1:0] fwd_enc(input logic [1:0] c);
        logic [1:0] s;
        case (c)
            2'd3:    s = FWD_EXMEM;
            2'd2:    s = FWD_MEMWB;
            2'd1:    s = FWD_WB;
            default: s = FWD_RF;
        endcase
        return s;
    endfunction

    assign haz_a_s = id_valid & reads_r1(op_s) & src_hazard(cnt_s[r1_s], ld_s[r1_s]);
    assign haz_b_s = id_valid & reads_r2(op_s) & src_hazard(cnt_s[r2_s], ld_s[r2_s]);
    assign stall_s = id_valid & ~flush & (haz_a_s | haz_b_s);
    assign issue_s = id_valid & ~stall_s & ~flush;
    assign stall   = stall_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            logic set_s;
            assign set_s = issue_s & writes_r1(op_s) & (r1_s == REG_W'(gi));
            hdu_sb_entry u_entry (
                .clk      (clk),
                .rst      (rst),
                .set_i    (set_s),
                .set_ld_i (is_load(op_s)),
                .cnt_o    (cnt_s[gi]),
                .ld_o     (ld_s[gi])
            );
            assign busy_vec[gi] = (cnt_s[gi] != 2'd0);
        end
    endgenerate

    // Forwarding selects follow the producer's stage; unused operands read the RF.
    always_comb begin
        fwd_sel_a = FWD_RF;
        fwd_sel_b = FWD_RF;
        if ((FWD_EN != 0) && id_valid) begin
            fwd_sel_a = reads_r1(op_s) ? fwd_enc(cnt_s[r1_s]) : FWD_RF;
            fwd_sel_b = reads_r2(op_s) ? fwd_enc(cnt_s[r2_s]) : FWD_RF;
        end else begin
            fwd_sel_a = FWD_RF;
            fwd_sel_b = FWD_RF;
        end
    end

    logic [CNT_W-1:0] scnt_q, scnt_d;

    // Stall-cycle counter saturates at all-ones.
    always_comb begin
        scnt_d = scnt_q;
        if (stall_s && !(&scnt_q)) begin
            scnt_d = scnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            scnt_d = scnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q <= {CNT_W{1'b0}};
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign stall_count = scnt_q;

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Directed bench for hdu_scoreboard: two instances (stall-only with a 2-bit
// counter, and forwarding); expectations are queued and checked by a monitor.
module tb_hdu_scoreboard;
    import hdu_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] id_instr;
    logic       id_valid;
    logic       flush;

    logic       stall0, stall1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [3:0] busy0, busy1;
    logic [1:0] cnt0;
    logic [15:0] cnt1;

    hdu_scoreboard #(.REG_W(2), .FWD_EN(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
        .stall(stall0), .fwd_sel_a(fa0), .fwd_sel_b(fb0), .busy_vec(busy0), .stall_count(cnt0)
    );

    hdu_scoreboard #(.REG_W(2), .FWD_EN(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
        .stall(stall1), .fwd_sel_a(fa1), .fwd_sel_b(fb1), .busy_vec(busy1), .stall_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    seq;
        int    dut;
        int    stall;
        int    fa;
        int    fb;
        int    busy;
        int    cnt;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   seq = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic logic [7:0] mk(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        return {1'b0, op, a, b};
    endfunction

    task automatic chk(input string nm, input string fld, input int act, input int want);
        if (want >= 0) begin
            n_tests++;
            if (act != want) begin
                n_fail++;
                $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, want);
            end
        end
    endtask

    // Monitor: compare every expectation tagged for the cycle currently presented.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].seq == seq) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "stall", e.dut != 0 ? int'(stall1) : int'(stall0), e.stall);
            chk(e.name, "fwd_a", e.dut != 0 ? int'(fa1)    : int'(fa0),    e.fa);
            chk(e.name, "fwd_b", e.dut != 0 ? int'(fb1)    : int'(fb0),    e.fb);
            chk(e.name, "busy",  e.dut != 0 ? int'(busy1)  : int'(busy0),  e.busy);
            chk(e.name, "count", e.dut != 0 ? int'(cnt1)   : int'(cnt0),   e.cnt);
        end
    end

    task automatic ex(input string nm, input int d, input int s, input int a, input int b,
                      input int bz, input int c);
        exp_t e;
        e.seq = seq; e.dut = d; e.stall = s; e.fa = a; e.fb = b; e.busy = bz; e.cnt = c;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [7:0] ins, input logic v, input logic fl, input logic r);
        id_instr = ins;
        id_valid = v;
        flush    = fl;
        rst      = r;
        @(posedge clk);
        #1;
        seq++;
    endtask

    task automatic do_reset();
        step(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        id_instr = 8'h00; id_valid = 1'b0; flush = 1'b0; rst = 1'b1;
        #1;
        do_reset();

        // 1: reset state under NOPs
        ex("s1_c0", 0, 0, 0, 0, 0, 0); ex("s1_c0", 1, 0, 0, 0, 0, 0);
        step(mk(OP_NOP, 2'd0, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s1_c1", 0, 0, 0, 0, 0, 0); ex("s1_c1", 1, 0, 0, 0, 0, 0);
        step(mk(OP_NOP, 2'd1, 2'd2), 1'b1, 1'b0, 1'b0);

        // 2: stall-until-writeback, then counter saturation (CNT_W=2)
        do_reset();
        ex("s2_c0", 0, 0, 0, 0, 4'b0000, 0);
        step(mk(OP_ADD, 2'd0, 2'd1), 1'b1, 1'b0, 1'b0);
        ex("s2_c1", 0, 1, 0, 0, 4'b0001, 0);
        step(mk(OP_ADD, 2'd2, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s2_c2", 0, 1, -1, -1, 4'b0001, 1);
        step(mk(OP_ADD, 2'd2, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s2_c3", 0, 1, -1, -1, 4'b0001, 2);
        step(mk(OP_ADD, 2'd2, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s2_c4", 0, 0, 0, 0, 4'b0000, 3);
        step(mk(OP_ADD, 2'd2, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s2_c5", 0, 1, -1, -1, 4'b0100, 3);
        step(mk(OP_ADD, 2'd3, 2'd2), 1'b1, 1'b0, 1'b0);
        ex("s2_sat", 0, 1, -1, -1, -1, 3);
        step(mk(OP_ADD, 2'd3, 2'd2), 1'b1, 1'b0, 1'b0);

        // 3: INC ignores its r2 field
        do_reset();
        step(mk(OP_INC, 2'd1, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s3_c1", 0, 0, -1, -1, 4'b0010, 0);
        step(mk(OP_INC, 2'd2, 2'd1), 1'b1, 1'b0, 1'b0);
        ex("s3_c2", 0, 0, -1, -1, 4'b0110, 0);
        step(mk(OP_NOP, 2'd0, 2'd0), 1'b1, 1'b0, 1'b0);

        // 4: forwarding chain, no stalls
        do_reset();
        ex("s4_c0", 1, 0, 0, 0, 4'b0000, 0);
        step(mk(OP_ADD, 2'd0, 2'd1), 1'b1, 1'b0, 1'b0);
        ex("s4_c1", 1, 0, 0, 1, -1, 0);
        step(mk(OP_ADD, 2'd3, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s4_c2", 1, 0, 0, 2, -1, 0);
        step(mk(OP_ADD, 2'd2, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s4_c3", 1, 0, 0, 3, -1, 0);
        step(mk(OP_ADD, 2'd1, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s4_c4", 1, 0, 0, 0, 4'b1110, 0);
        step(mk(OP_NOP, 2'd0, 2'd0), 1'b1, 1'b0, 1'b0);

        // 5: load-use costs exactly one stall
        do_reset();
        ex("s5_c0", 1, 0, -1, -1, -1, 0);
        step(mk(OP_LD, 2'd1, 2'd2), 1'b1, 1'b0, 1'b0);
        ex("s5_c1", 1, 1, -1, -1, 4'b0010, 0);
        step(mk(OP_ADD, 2'd0, 2'd1), 1'b1, 1'b0, 1'b0);
        ex("s5_c2", 1, 0, 0, 2, -1, 1);
        step(mk(OP_ADD, 2'd0, 2'd1), 1'b1, 1'b0, 1'b0);

        // 6: same register on both operands
        do_reset();
        step(mk(OP_ADD, 2'd0, 2'd1), 1'b1, 1'b0, 1'b0);
        ex("s6_same", 1, 0, 1, 1, -1, 0);
        step(mk(OP_ADD, 2'd0, 2'd0), 1'b1, 1'b0, 1'b0);

        // 7: flush suppresses stall and issue, then reset mid-stall
        do_reset();
        step(mk(OP_ADD, 2'd0, 2'd1), 1'b1, 1'b0, 1'b0);
        ex("s7_c1", 0, 0, -1, -1, 4'b0001, 0);
        step(mk(OP_INC, 2'd3, 2'd0), 1'b1, 1'b0, 1'b0);
        ex("s7_flush", 0, 0, -1, -1, 4'b1001, 0);
        step(mk(OP_ADD, 2'd2, 2'd3), 1'b1, 1'b1, 1'b0);
        ex("s7_prerst", 0, 1, -1, -1, 4'b1001, 0);
        step(mk(OP_ADD, 2'd2, 2'd3), 1'b1, 1'b0, 1'b1);
        ex("s7_postrst", 0, 0, 0, 0, 4'b0000, 0);
        step(mk(OP_ADD, 2'd2, 2'd3), 1'b1, 1'b0, 1'b0);

        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked expectations expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
